id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
ID/EX pipeline register for the 5-stage RV32 core, directly downstream of the ID-stage control decoder. Each cycle it captures the decoder's control bundle and the ID operands, register indices and immediate, and drives them to EX. It contains the load-use hazard detector: it inserts a bubble into EX and requests a hold of PC and IF/ID. It honours EX-side flush (taken branch) and downstream stall, and counts inserted bubbles.

Parameters:
DATA_W, 32, width of PC, register operands and immediate
CNT_W, 16, width of saturating bubble counter

Ports:
clk_i  input  1  core clock, all state updates on rising edge
rst_i  input  1  asynchronous reset, active-high
id_valid_i  input  1  ID holds a real instruction
id_opcode_i  input  7  instr[6:0], used for operand-use decode
id_reg_write_i  input  1  control bundle from decoder
id_alu_op_i  input  2  control bundle from decoder
id_alu_src_i  input  1  control bundle from decoder
id_branch_i  input  1  control bundle from decoder
id_mem_write_i  input  1  control bundle from decoder
id_mem_read_i  input  1  control bundle from decoder
id_mem_to_reg_i  input  1  control bundle from decoder
id_pc_i  input  DATA_W  PC of ID instruction
id_rs1_data_i, id_rs2_data_i  input  DATA_W  register-file read data
id_imm_i  input  DATA_W  sign-extended immediate
id_rs1_i, id_rs2_i, id_rd_i  input  5  register indices
id_funct_i  input  4  {instr[30], instr[14:12]} for ALU control
flush_i  input  1  taken branch/redirect from EX: squash ID->EX transfer
ex_stall_i  input  1  EX cannot accept: hold current EX contents
ex_valid_o  output  1  EX slot holds a real instruction
ex_reg_write_o, ex_alu_src_o, ex_branch_o, ex_mem_write_o, ex_mem_read_o, ex_mem_to_reg_o  output  1 each  registered control
ex_alu_op_o  output  2  registered control
ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o  output  DATA_W  registered data
ex_rs1_o, ex_rs2_o, ex_rd_o  output  5  registered indices
ex_funct_o  output  4  registered funct
id_hold_o  output  1  combinational: freeze PC and IF/ID this cycle
bubble_cnt_o  output  CNT_W  saturating count of load-use bubbles

Behaviour:
- Reset (async, rst_i=1): every registered output = 0, including ex_valid_o, all control, data, indices, funct and bubble_cnt_o. Outputs stay 0 while rst_i is held. Normal operation starts at the first rising edge after deassertion.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- Operand use, decoded from id_opcode_i:
  - rs1_used = 0 for LUI 0110111, AUIPC 0010111, JAL 1101111; 1 otherwise.
  - rs2_used = 1 only for R-type 0110011, store 0100011, branch 1100011.
- load_use = id_valid_i & ex_valid_o & ex_mem_read_o & (ex_rd_o != 0) & ((rs1_used & id_rs1_i==ex_rd_o) | (rs2_used & id_rs2_i==ex_rd_o)).
- id_hold_o = (load_use | ex_stall_i) & ~flush_i. Purely combinational, no registered delay.
- Per-edge update, first matching rule wins:
  1. flush_i=1: load bubble.
  2. ex_stall_i=1: hold all ex_* outputs unchanged.
  3. load_use=1: load bubble; bubble_cnt_o += 1, saturating at all-ones.
  4. Otherwise: load all ID inputs; ex_valid_o = id_valid_i. If id_valid_i=0, control and ex_rd_o are forced to 0.
- Bubble load: ex_valid_o, all control outputs and ex_rd_o = 0. Data, rs1/rs2 and funct fields load from ID inputs and are don't-care.
- A bubble or invalid slot must never assert ex_reg_write_o, ex_mem_write_o, ex_mem_read_o or ex_branch_o.
- load_use is evaluated against current EX contents. After one bubble, EX holds no load, so a single load-use costs exactly 1 stall cycle.
- Simultaneous flush_i with ex_stall_i or load_use: flush wins and id_hold_o = 0.
- Counter: increments only under rule 3. Holds at 2^CNT_W-1. Cleared only by reset.

Test Plan:
- Reset mid-stream: drive valid instructions, assert rst_i between edges. All ex_* outputs and bubble_cnt_o go to 0 immediately (asynchronously) and stay 0 until release.
- Plain pass-through: ID add (opcode 0110011, rd=5, rs1=1, rs2=2, pc=0x10, funct=4'b0000), no hazards. Next cycle ex_* match inputs, ex_valid_o=1, id_hold_o=0.
- Load-use, then rs2 case:
  - EX holds lw rd=3 (mem_read=1); ID holds add rs1=3. id_hold_o=1. Next edge: EX bubble, ex_valid_o=0, bubble_cnt_o=1. Following edge: the add loads.
  - Same with ID sw rs2=3 gives the same stall.
- Non-hazards:
  - EX lw rd=0, ID rs1=0: no stall.
  - EX lw rd=3, ID lui (opcode 0110111) with rs1 field=3: no stall.
  - EX lw rd=3, ID addi with rs2 field=3: no stall.
- Priority: flush_i=1 together with load_use=1 and ex_stall_i=1. id_hold_o=0, next EX is a bubble, bubble_cnt_o unchanged. Then ex_stall_i=1 alone for 3 cycles: ex_* frozen and id_hold_o=1 throughout.
- Counter saturation: with CNT_W=2, force 5 consecutive load-use bubbles. bubble_cnt_o reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX boundary bundle: decoder control, ID operands and EX-side handshake.
// The master side is the ID stage/core glue; the slave side is the pipeline register.
interface id_ex_pipe_reg_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              id_valid_i;
  logic [6:0]        id_opcode_i;
  logic              id_reg_write_i;
  logic [1:0]        id_alu_op_i;
  logic              id_alu_src_i;
  logic              id_branch_i;
  logic              id_mem_write_i;
  logic              id_mem_read_i;
  logic              id_mem_to_reg_i;
  logic [DATA_W-1:0] id_pc_i;
  logic [DATA_W-1:0] id_rs1_data_i;
  logic [DATA_W-1:0] id_rs2_data_i;
  logic [DATA_W-1:0] id_imm_i;
  logic [4:0]        id_rs1_i;
  logic [4:0]        id_rs2_i;
  logic [4:0]        id_rd_i;
  logic [3:0]        id_funct_i;
  logic              flush_i;
  logic              ex_stall_i;

  logic              ex_valid_o;
  logic              ex_reg_write_o;
  logic              ex_alu_src_o;
  logic              ex_branch_o;
  logic              ex_mem_write_o;
  logic              ex_mem_read_o;
  logic              ex_mem_to_reg_o;
  logic [1:0]        ex_alu_op_o;
  logic [DATA_W-1:0] ex_pc_o;
  logic [DATA_W-1:0] ex_rs1_data_o;
  logic [DATA_W-1:0] ex_rs2_data_o;
  logic [DATA_W-1:0] ex_imm_o;
  logic [4:0]        ex_rs1_o;
  logic [4:0]        ex_rs2_o;
  logic [4:0]        ex_rd_o;
  logic [3:0]        ex_funct_o;
  logic              id_hold_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  modport master (
    output id_valid_i, id_opcode_i, id_reg_write_i, id_alu_op_i, id_alu_src_i,
           id_branch_i, id_mem_write_i, id_mem_read_i, id_mem_to_reg_i, id_pc_i,
           id_rs1_data_i, id_rs2_data_i, id_imm_i, id_rs1_i, id_rs2_i, id_rd_i,
           id_funct_i, flush_i, ex_stall_i,
    input  ex_valid_o, ex_reg_write_o, ex_alu_src_o, ex_branch_o, ex_mem_write_o,
           ex_mem_read_o, ex_mem_to_reg_o, ex_alu_op_o, ex_pc_o, ex_rs1_data_o,
           ex_rs2_data_o, ex_imm_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct_o,
           id_hold_o, bubble_cnt_o
  );

  modport slave (
    input  id_valid_i, id_opcode_i, id_reg_write_i, id_alu_op_i, id_alu_src_i,
           id_branch_i, id_mem_write_i, id_mem_read_i, id_mem_to_reg_i, id_pc_i,
           id_rs1_data_i, id_rs2_data_i, id_imm_i, id_rs1_i, id_rs2_i, id_rd_i,
           id_funct_i, flush_i, ex_stall_i,
    output ex_valid_o, ex_reg_write_o, ex_alu_src_o, ex_branch_o, ex_mem_write_o,
           ex_mem_read_o, ex_mem_to_reg_o, ex_alu_op_o, ex_pc_o, ex_rs1_data_o,
           ex_rs2_data_o, ex_imm_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct_o,
           id_hold_o, bubble_cnt_o
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush/stall handling
// and a saturating count of inserted load-use bubbles.
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input logic              clk_i,
  input logic              rst_i,
  id_ex_pipe_reg_if.slave  bus
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic rs1Used;
  logic rs2Used;
  logic loadUse;
  logic advance;
  logic slotLive;
  logic countBubble;

  // Which source registers the ID instruction actually reads
  always_comb begin
    rs1Used = 1'b1;
    rs2Used = 1'b0;
    case (bus.id_opcode_i)
      OP_LUI, OP_AUIPC, OP_JAL:      rs1Used = 1'b0;
      OP_RTYPE, OP_STORE, OP_BRANCH: rs2Used = 1'b1;
      default: begin
        rs1Used = 1'b1;
        rs2Used = 1'b0;
      end
    endcase
  end

  // Hazard detection and the EX-slot update decision for this edge
  always_comb begin
    loadUse = bus.id_valid_i & bus.ex_valid_o & bus.ex_mem_read_o
            & (bus.ex_rd_o != 5'd0)
            & ((rs1Used & (bus.id_rs1_i == bus.ex_rd_o))
             | (rs2Used & (bus.id_rs2_i == bus.ex_rd_o)));
    bus.id_hold_o = (loadUse | bus.ex_stall_i) & ~bus.flush_i;
    // A flush overrides a stall, so the slot moves whenever either is true
    advance     = ~bus.ex_stall_i | bus.flush_i;
    slotLive    = bus.id_valid_i & ~bus.flush_i & ~loadUse;
    countBubble = ~bus.flush_i & ~bus.ex_stall_i & loadUse;
  end

  // EX slot register and bubble counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.ex_valid_o      <= 1'b0;
      bus.ex_reg_write_o  <= 1'b0;
      bus.ex_alu_src_o    <= 1'b0;
      bus.ex_branch_o     <= 1'b0;
      bus.ex_mem_write_o  <= 1'b0;
      bus.ex_mem_read_o   <= 1'b0;
      bus.ex_mem_to_reg_o <= 1'b0;
      bus.ex_alu_op_o     <= 2'b00;
      bus.ex_pc_o         <= {DATA_W{1'b0}};
      bus.ex_rs1_data_o   <= {DATA_W{1'b0}};
      bus.ex_rs2_data_o   <= {DATA_W{1'b0}};
      bus.ex_imm_o        <= {DATA_W{1'b0}};
      bus.ex_rs1_o        <= 5'd0;
      bus.ex_rs2_o        <= 5'd0;
      bus.ex_rd_o         <= 5'd0;
      bus.ex_funct_o      <= 4'd0;
      bus.bubble_cnt_o    <= {CNT_W{1'b0}};
    end else if (advance) begin
      // Data fields always follow ID; they are meaningless when the slot is a bubble
      bus.ex_pc_o         <= bus.id_pc_i;
      bus.ex_rs1_data_o   <= bus.id_rs1_data_i;
      bus.ex_rs2_data_o   <= bus.id_rs2_data_i;
      bus.ex_imm_o        <= bus.id_imm_i;
      bus.ex_rs1_o        <= bus.id_rs1_i;
      bus.ex_rs2_o        <= bus.id_rs2_i;
      bus.ex_funct_o      <= bus.id_funct_i;
      bus.ex_valid_o      <= slotLive;
      bus.ex_reg_write_o  <= bus.id_reg_write_i  & slotLive;
      bus.ex_alu_src_o    <= bus.id_alu_src_i    & slotLive;
      bus.ex_branch_o     <= bus.id_branch_i     & slotLive;
      bus.ex_mem_write_o  <= bus.id_mem_write_i  & slotLive;
      bus.ex_mem_read_o   <= bus.id_mem_read_i   & slotLive;
      bus.ex_mem_to_reg_o <= bus.id_mem_to_reg_i & slotLive;
      bus.ex_alu_op_o     <= bus.id_alu_op_i & {2{slotLive}};
      bus.ex_rd_o         <= slotLive ? bus.id_rd_i : 5'd0;
      if (countBubble && (bus.bubble_cnt_o != {CNT_W{1'b1}})) begin
        bus.bubble_cnt_o <= bus.bubble_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed hazard table, hand sequences
// for priority/reset/saturation, and randomized traffic against a reference model.
module tb_id_ex_pipe_reg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic        valid;
    logic        regWrite;
    logic [1:0]  aluOp;
    logic        aluSrc;
    logic        branch;
    logic        memWrite;
    logic        memRead;
    logic        memToReg;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  funct;
  } slot_t;

  typedef struct {
    logic [4:0] exRd;
    logic [6:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    bit         expHold;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  slot_t idIn;
  logic [6:0] idOp;
  logic  flush;
  logic  stall;
  slot_t exAct;
  slot_t mEx;
  logic [15:0] mCnt;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg_if #(.DATA_W(32), .CNT_W(16)) bus ();
  id_ex_pipe_reg_if #(.DATA_W(32), .CNT_W(2))  busSat ();

  id_ex_pipe_reg #(.DATA_W(32), .CNT_W(16)) dut    (.clk_i(clk), .rst_i(rst), .bus(bus));
  id_ex_pipe_reg #(.DATA_W(32), .CNT_W(2))  dutSat (.clk_i(clk), .rst_i(rst), .bus(busSat));

  assign bus.id_valid_i      = idIn.valid;    assign busSat.id_valid_i      = idIn.valid;
  assign bus.id_opcode_i     = idOp;          assign busSat.id_opcode_i     = idOp;
  assign bus.id_reg_write_i  = idIn.regWrite; assign busSat.id_reg_write_i  = idIn.regWrite;
  assign bus.id_alu_op_i     = idIn.aluOp;    assign busSat.id_alu_op_i     = idIn.aluOp;
  assign bus.id_alu_src_i    = idIn.aluSrc;   assign busSat.id_alu_src_i    = idIn.aluSrc;
  assign bus.id_branch_i     = idIn.branch;   assign busSat.id_branch_i     = idIn.branch;
  assign bus.id_mem_write_i  = idIn.memWrite; assign busSat.id_mem_write_i  = idIn.memWrite;
  assign bus.id_mem_read_i   = idIn.memRead;  assign busSat.id_mem_read_i   = idIn.memRead;
  assign bus.id_mem_to_reg_i = idIn.memToReg; assign busSat.id_mem_to_reg_i = idIn.memToReg;
  assign bus.id_pc_i         = idIn.pc;       assign busSat.id_pc_i         = idIn.pc;
  assign bus.id_rs1_data_i   = idIn.rs1d;     assign busSat.id_rs1_data_i   = idIn.rs1d;
  assign bus.id_rs2_data_i   = idIn.rs2d;     assign busSat.id_rs2_data_i   = idIn.rs2d;
  assign bus.id_imm_i        = idIn.imm;      assign busSat.id_imm_i        = idIn.imm;
  assign bus.id_rs1_i        = idIn.rs1;      assign busSat.id_rs1_i        = idIn.rs1;
  assign bus.id_rs2_i        = idIn.rs2;      assign busSat.id_rs2_i        = idIn.rs2;
  assign bus.id_rd_i         = idIn.rd;       assign busSat.id_rd_i         = idIn.rd;
  assign bus.id_funct_i      = idIn.funct;    assign busSat.id_funct_i      = idIn.funct;
  assign bus.flush_i         = flush;         assign busSat.flush_i         = flush;
  assign bus.ex_stall_i      = stall;         assign busSat.ex_stall_i      = stall;

  assign exAct = {bus.ex_valid_o, bus.ex_reg_write_o, bus.ex_alu_op_o, bus.ex_alu_src_o,
                  bus.ex_branch_o, bus.ex_mem_write_o, bus.ex_mem_read_o, bus.ex_mem_to_reg_o,
                  bus.ex_pc_o, bus.ex_rs1_data_o, bus.ex_rs2_data_o, bus.ex_imm_o,
                  bus.ex_rs1_o, bus.ex_rs2_o, bus.ex_rd_o, bus.ex_funct_o};

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: an instruction reads rs1 unless it is LUI/AUIPC/JAL, and rs2 only for R/S/B.
  function automatic bit readsRs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic bit readsRs2(input logic [6:0] op);
    return (op == OP_RTYPE || op == OP_STORE || op == OP_BRANCH);
  endfunction

  function automatic bit hazard();
    if (!(idIn.valid && mEx.valid && mEx.memRead && mEx.rd != 5'd0)) return 1'b0;
    return (readsRs1(idOp) && idIn.rs1 == mEx.rd) || (readsRs2(idOp) && idIn.rs2 == mEx.rd);
  endfunction

  function automatic slot_t squash(input slot_t s);
    slot_t r = s;
    r.valid = 1'b0; r.regWrite = 1'b0; r.aluOp = 2'b00; r.aluSrc = 1'b0; r.branch = 1'b0;
    r.memWrite = 1'b0; r.memRead = 1'b0; r.memToReg = 1'b0; r.rd = 5'd0;
    return r;
  endfunction

  // Payload of an empty slot is don't-care; only valid, control and rd are compared there.
  function automatic slot_t visible(input slot_t s);
    slot_t r = s;
    if (!r.valid) begin
      r.pc = 32'd0; r.rs1d = 32'd0; r.rs2d = 32'd0; r.imm = 32'd0;
      r.rs1 = 5'd0; r.rs2 = 5'd0; r.funct = 4'd0;
    end
    return r;
  endfunction

  task automatic setId(input bit v, input logic [6:0] op, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] d);
    idOp          = op;
    idIn.valid    = v;
    idIn.memRead  = (op == OP_LOAD);
    idIn.memToReg = (op == OP_LOAD);
    idIn.memWrite = (op == OP_STORE);
    idIn.branch   = (op == OP_BRANCH);
    idIn.regWrite = !(op == OP_STORE || op == OP_BRANCH);
    idIn.aluSrc   = !(op == OP_RTYPE || op == OP_BRANCH);
    idIn.aluOp    = (op == OP_RTYPE) ? 2'b10 : ((op == OP_BRANCH) ? 2'b01 : 2'b00);
    idIn.pc       = $urandom;
    idIn.rs1d     = $urandom;
    idIn.rs2d     = $urandom;
    idIn.imm      = $urandom;
    idIn.funct    = 4'($urandom_range(15, 0));
    idIn.rs1      = r1;
    idIn.rs2      = r2;
    idIn.rd       = d;
  endtask

  // One clock: check the combinational hold, take the edge, advance the model, compare EX.
  task automatic tick(input string tag);
    bit hz;
    #1;
    hz = hazard();
    chk({tag, ".hold"}, bus.id_hold_o, (hz || stall) && !flush);
    @(posedge clk);
    #1;
    if (flush) begin
      mEx = squash(idIn);
    end else if (stall) begin
      mEx = mEx;
    end else if (hz) begin
      mEx = squash(idIn);
      if (mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
    end else begin
      mEx = idIn.valid ? idIn : squash(idIn);
    end
    chk({tag, ".ex"}, visible(exAct), visible(mEx));
    chk({tag, ".cnt"}, bus.bubble_cnt_o, mCnt);
  endtask

  vec_t vecs[10];
  logic [1:0] satExp[5];
  logic [6:0] opList[9];

  initial begin
    vecs[0] = '{5'd3, OP_RTYPE,  5'd3, 5'd7, 1'b1};
    vecs[1] = '{5'd3, OP_STORE,  5'd9, 5'd3, 1'b1};
    vecs[2] = '{5'd0, OP_RTYPE,  5'd0, 5'd1, 1'b0};
    vecs[3] = '{5'd3, OP_LUI,    5'd3, 5'd3, 1'b0};
    vecs[4] = '{5'd3, OP_IMM,    5'd4, 5'd3, 1'b0};
    vecs[5] = '{5'd3, OP_BRANCH, 5'd8, 5'd3, 1'b1};
    vecs[6] = '{5'd3, OP_JAL,    5'd3, 5'd3, 1'b0};
    vecs[7] = '{5'd3, OP_AUIPC,  5'd3, 5'd0, 1'b0};
    vecs[8] = '{5'd5, OP_LOAD,   5'd5, 5'd0, 1'b1};
    vecs[9] = '{5'd5, OP_RTYPE,  5'd4, 5'd6, 1'b0};
    satExp  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    opList  = '{OP_LUI, OP_AUIPC, OP_JAL, OP_RTYPE, OP_STORE, OP_BRANCH, OP_LOAD, OP_IMM, OP_JALR};

    flush = 1'b0;
    stall = 1'b0;
    setId(1'b1, OP_LOAD, 5'd1, 5'd2, 5'd3);
    mEx  = '0;
    mCnt = 16'd0;

    // Outputs must be zero while reset is held, even with live ID traffic
    #12;
    chk("reset.ex", exAct, 160'd0);
    chk("reset.cnt", bus.bubble_cnt_o, 160'd0);
    @(negedge clk);
    rst = 1'b0;

    // Plain pass-through of an add
    setId(1'b1, OP_RTYPE, 5'd1, 5'd2, 5'd5);
    idIn.pc    = 32'h10;
    idIn.funct = 4'b0000;
    tick("pass");
    chk("pass.valid", bus.ex_valid_o, 160'd1);
    chk("pass.rd", bus.ex_rd_o, 160'd5);
    chk("pass.pc", bus.ex_pc_o, 160'h10);

    // Directed hazard table: EX holds a load to exRd, ID presents the vector instruction
    for (int i = 0; i < 10; i++) begin
      setId(1'b0, OP_IMM, 5'd0, 5'd0, 5'd0);
      tick("tbl.clr");
      setId(1'b1, OP_LOAD, 5'd1, 5'd0, vecs[i].exRd);
      tick("tbl.ld");
      setId(1'b1, vecs[i].op, vecs[i].rs1, vecs[i].rs2, 5'd6);
      #1;
      chk($sformatf("tbl%0d.hold", i), bus.id_hold_o, vecs[i].expHold);
      tick("tbl.use");
      chk($sformatf("tbl%0d.valid", i), bus.ex_valid_o, !vecs[i].expHold);
      if (vecs[i].expHold) begin
        tick("tbl.retry");
        chk($sformatf("tbl%0d.retry", i), bus.ex_valid_o, 160'd1);
      end
    end

    // Flush beats stall and load-use; then stall alone freezes a live slot
    setId(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd3);
    tick("prio.ld");
    setId(1'b1, OP_RTYPE, 5'd3, 5'd4, 5'd7);
    flush = 1'b1;
    stall = 1'b1;
    #1;
    chk("prio.hold", bus.id_hold_o, 160'd0);
    tick("prio.flush");
    chk("prio.bubble", bus.ex_valid_o, 160'd0);
    flush = 1'b0;
    stall = 1'b0;
    setId(1'b1, OP_RTYPE, 5'd1, 5'd2, 5'd9);
    tick("prio.fill");
    stall = 1'b1;
    setId(1'b1, OP_LOAD, 5'd9, 5'd9, 5'd10);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d.hold", i), bus.id_hold_o, 160'd1);
      tick("stall");
    end
    stall = 1'b0;

    // Mid-stream asynchronous reset between edges
    tick("pre.rst");
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.ex", exAct, 160'd0);
    chk("midrst.cnt", bus.bubble_cnt_o, 160'd0);
    chk("midrst.sat", busSat.bubble_cnt_o, 160'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst.held", exAct, 160'd0);
    mEx  = '0;
    mCnt = 16'd0;
    @(negedge clk);
    rst = 1'b0;

    // Repeated lw x3,0(x3): every other edge is a load-use bubble
    setId(1'b1, OP_LOAD, 5'd3, 5'd0, 5'd3);
    tick("sat.first");
    for (int k = 0; k < 5; k++) begin
      tick("sat.bub");
      chk($sformatf("sat%0d.cnt", k), busSat.bubble_cnt_o, satExp[k]);
      tick("sat.load");
    end

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      setId($urandom_range(99, 0) < 85, opList[$urandom_range(8, 0)],
            5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)));
      flush = ($urandom_range(9, 0) == 0);
      stall = ($urandom_range(5, 0) == 0);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
